// File: rtl/gsram_sync.sv
// Clocked word-wide SRAM model: strobe request, WAIT_CYCLES wait states, then a one-cycle ready/error completion.
// Latency WAIT_CYCLES+1 cycles from acceptance; busy blocks new requests until the ready cycle has ended.
module gsram_sync #(
   parameter int SIZE        = 256,
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    ready,
   output logic                    error,
   output logic                    busy
);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    rd_q, rd_d, wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0]   mem [SIZE];

   logic                    acc_rd, acc_wr, acc_in_range, enter_done, mem_we;
   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_wdata;
   logic [BE_W-1:0]         acc_be;
   logic [IDX_W-1:0]        acc_idx;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      case (state_q)
         S_IDLE: begin
            if (read || write) begin
               rd_d    = read;
               wr_d    = write;
               addr_d  = address;
               wdata_d = wdata;
               be_d    = byte_en;
               cnt_d   = 8'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accepting edge, so use the live inputs.
   always_comb begin
      acc_rd       = (state_q == S_IDLE) ? read    : rd_q;
      acc_wr       = (state_q == S_IDLE) ? write   : wr_q;
      acc_addr     = (state_q == S_IDLE) ? address : addr_q;
      acc_wdata    = (state_q == S_IDLE) ? wdata   : wdata_q;
      acc_be       = (state_q == S_IDLE) ? byte_en : be_q;
      acc_idx      = acc_addr[IDX_W-1:0];
      acc_in_range = ({1'b0, acc_addr} < SIZE_W);
      enter_done   = (state_d == S_DONE) && (state_q != S_DONE);
      mem_we       = enter_done && acc_wr && !acc_rd && acc_in_range;
      rdata_d      = rdata_q;
      if (enter_done && acc_rd && !acc_wr)
         rdata_d = acc_in_range ? mem[acc_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (rstn && mem_we) begin
         for (int i = 0; i < BE_W; i++)
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
   end

   always_comb begin
      ready = (state_q == S_DONE);
      busy  = (state_q != S_IDLE);
      error = ready && ((rd_q && wr_q) || ({1'b0, addr_q} >= SIZE_W));
      rdata = rdata_q;
   end
endmodule
